// File: rtl/battleship_cfg_pkg.sv
// Shared types and constants for the ship-count configuration block and its
// button front-end.
package battleship_cfg_pkg;

    typedef enum logic [1:0] {
        WAIT_PRESS   = 2'd0,
        WAIT_RELEASE = 2'd1,
        DONE         = 2'd2
    } cfgState_t;

    localparam int MAX_SHIPS_DEF = 5;
    localparam int MIN_SHIPS_DEF = 1;

    function automatic int cnt_width(input int maxShips);
        return $clog2(maxShips + 1);
    endfunction

    function automatic int player_width(input int numPlayers);
        return (numPlayers > 1) ? $clog2(numPlayers) : 1;
    endfunction

endpackage

// File: rtl/ship_count_config_if.sv
// Board-side signal bundle of ship_count_config: switches/button/restart in,
// latched per-player counts and status out, plus FSM/debounce visibility.
interface ship_count_config_if
    import battleship_cfg_pkg::*;
#(
    parameter int MAX_SHIPS   = MAX_SHIPS_DEF,
    parameter int NUM_PLAYERS = 2
);
    localparam int CNT_W = cnt_width(MAX_SHIPS);
    localparam int PW    = player_width(NUM_PLAYERS);

    logic [CNT_W-1:0]             ship_count_in;
    logic                         select_btn;
    logic                         restart;
    logic [NUM_PLAYERS*CNT_W-1:0] ship_count;
    logic [NUM_PLAYERS-1:0]       count_valid;
    logic [PW-1:0]                current_player;
    logic                         range_error;
    logic                         select_done;
    cfgState_t                    fsmState;
    logic                         debounced;

    // No handshake: count_valid bits and select_done are sticky levels until
    // reset/restart; range_error is a one-cycle pulse per rejected press.
    modport master (
        output ship_count_in, select_btn, restart,
        input  ship_count, count_valid, current_player, range_error,
               select_done, fsmState, debounced
    );

    modport slave (
        input  ship_count_in, select_btn, restart,
        output ship_count, count_valid, current_player, range_error,
               select_done, fsmState, debounced
    );

endinterface

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus stability counter for a raw pushbutton; emits
// one-cycle rise/fall pulses on the same edge the debounced level toggles.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic btnRaw,
    output logic rise,
    output logic fall,
    output logic level
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          syncA;
    logic          btnS;
    logic          primed;
    logic [CW-1:0] stableCnt;
    logic          differs;
    logic          expire;

    // Until primed, the counter measures a stable low instead, so a button
    // still held after clear never produces a rise ("release before reset").
    assign differs = primed ? (btnS != level) : !btnS;
    assign expire  = differs && (stableCnt == LAST);
    assign rise    = primed && expire && btnS;
    assign fall    = primed && expire && !btnS;

    always_ff @(posedge clk) begin
        if (clear) begin
            syncA     <= 1'b0;
            btnS      <= 1'b0;
            primed    <= 1'b0;
            level     <= 1'b0;
            stableCnt <= '0;
        end else begin
            syncA <= btnRaw;
            btnS  <= syncA;
            if (!differs) begin
                stableCnt <= '0;
            end else if (expire) begin
                stableCnt <= '0;
                if (primed) level  <= btnS;
                else        primed <= 1'b1;
            end else begin
                stableCnt <= stableCnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ship_count_config.sv
// Collects a debounced, range-checked ship count for each player in turn and
// raises select_done once every player has a latched count.
module ship_count_config
    import battleship_cfg_pkg::*;
#(
    parameter int MAX_SHIPS       = MAX_SHIPS_DEF,
    parameter int MIN_SHIPS       = MIN_SHIPS_DEF,
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SAME_COUNT      = 0
) (
    input logic          clk,
    input logic          reset,
    ship_count_config_if.slave bus
);
    localparam int            CNT_W       = cnt_width(MAX_SHIPS);
    localparam int            PW          = player_width(NUM_PLAYERS);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

    cfgState_t                    state;
    logic [NUM_PLAYERS*CNT_W-1:0] shipCount;
    logic [NUM_PLAYERS-1:0]       countValid;
    logic [PW-1:0]                curPlayer;
    logic                         rangeError;
    logic                         selectDone;
    logic                         btnRise;
    logic                         btnFall;
    logic                         btnLevel;
    logic                         legal;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDeb (
        .clk    (clk),
        .clear  (reset || bus.restart),
        .btnRaw (bus.select_btn),
        .rise   (btnRise),
        .fall   (btnFall),
        .level  (btnLevel)
    );

    assign legal = (bus.ship_count_in >= CNT_W'(MIN_SHIPS)) &&
                   (bus.ship_count_in <= CNT_W'(MAX_SHIPS));

    always_ff @(posedge clk) begin
        if (reset || bus.restart) begin
            state      <= WAIT_PRESS;
            shipCount  <= '0;
            countValid <= '0;
            curPlayer  <= '0;
            rangeError <= 1'b0;
            selectDone <= 1'b0;
        end else begin
            rangeError <= 1'b0;
            case (state)
                WAIT_PRESS: begin
                    if (btnRise) begin
                        if (!legal) begin
                            rangeError <= 1'b1;
                            state      <= WAIT_RELEASE;
                        end else if (SAME_COUNT != 0) begin
                            for (int p = 0; p < NUM_PLAYERS; p++)
                                shipCount[p*CNT_W +: CNT_W] <= bus.ship_count_in;
                            countValid <= '1;
                            selectDone <= 1'b1;
                            state      <= DONE;
                        end else begin
                            shipCount[curPlayer*CNT_W +: CNT_W] <= bus.ship_count_in;
                            countValid[curPlayer] <= 1'b1;
                            // The last player finishes here, so curPlayer never wraps.
                            if (curPlayer == LAST_PLAYER) begin
                                selectDone <= 1'b1;
                                state      <= DONE;
                            end else begin
                                curPlayer <= curPlayer + PW'(1);
                                state     <= WAIT_RELEASE;
                            end
                        end
                    end
                end
                WAIT_RELEASE: if (btnFall) state <= WAIT_PRESS;
                DONE:         state <= DONE;
                default:      state <= WAIT_PRESS;
            endcase
        end
    end

    assign bus.ship_count     = shipCount;
    assign bus.count_valid    = countValid;
    assign bus.current_player = curPlayer;
    assign bus.range_error    = rangeError;
    assign bus.select_done    = selectDone;
    assign bus.fsmState       = state;
    assign bus.debounced      = btnLevel;

endmodule

// File: doc/ship_count_config.md
Name: ship_count_config

Overview:
- Parametrised successor to the single-player ship-count selector.
- Collects a debounced, range-checked ship count for each of NUM_PLAYERS players in turn, then raises select_done for the game FSM.
- Sits between board switches/pushbutton and the placement/turn logic.
- Adds over the previous generation:
  - button synchroniser and debouncer
  - min/max range check with an error pulse
  - per-player storage
  - a shared-count mode
  - restart without full reset

Parameters:
- MAX_SHIPS, 5: largest legal ship count.
- MIN_SHIPS, 1: smallest legal ship count. Must satisfy 1 ≤ MIN_SHIPS ≤ MAX_SHIPS.
- NUM_PLAYERS, 2: players to configure, 1..4.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a press or a release, ≥ 1.
- SAME_COUNT, 0: when 1, the first accepted press sets every player's count and goes straight to DONE.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- ship_count_in, input, CNT_W: switch value. Must be stable while the button is held. CNT_W = $clog2(MAX_SHIPS+1).
- select_btn, input, 1: raw pushbutton, asynchronous, bouncy.
- restart, input, 1: synchronous clear to the first player. Same effect as reset.
- ship_count, output, NUM_PLAYERS*CNT_W: latched counts. Player p occupies bits [p*CNT_W +: CNT_W].
- count_valid, output, NUM_PLAYERS: bit p set once player p's count is latched.
- current_player, output, max(1,$clog2(NUM_PLAYERS)): player currently being configured.
- range_error, output, 1: one-cycle pulse when an accepted press carries an illegal value.
- select_done, output, 1: level. High once all players are configured.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - Priority: reset > restart > button events.
- Reset/restart values:
  - ship_count = 0, count_valid = 0, current_player = 0, range_error = 0, select_done = 0.
  - State = WAIT_PRESS. Synchroniser flops = 0. Debounce counter = 0.
- Synchroniser:
  - select_btn passes through 2 flops to give btn_s.
- Debounce counter:
  - Counts consecutive cycles in which btn_s differs from the debounced level.
  - Resets to 0 on any cycle where btn_s equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles on that same edge.
- Press latency:
  - Let E be the first edge that samples select_btn = 1.
  - The accept takes effect at edge E+1+DEBOUNCE_CYCLES. With defaults this is E+5.
  - Outputs are visible after that edge.
- FSM states: WAIT_PRESS, WAIT_RELEASE, DONE.
- WAIT_PRESS, on debounced rise (accept edge); ship_count_in is sampled on this edge:
  - Legal value (MIN_SHIPS ≤ v ≤ MAX_SHIPS), SAME_COUNT = 0:
    - Write v to slot current_player and set count_valid[current_player].
    - If current_player = NUM_PLAYERS-1: go to DONE and set select_done = 1 on the same edge.
    - Otherwise: increment current_player and go to WAIT_RELEASE.
  - Legal value, SAME_COUNT = 1:
    - Write v to all slots and set count_valid to all ones.
    - Set select_done = 1 and go to DONE.
  - Illegal value:
    - range_error = 1 for exactly one cycle.
    - No slot written; current_player unchanged.
    - Go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Debounced fall returns to WAIT_PRESS. A held button never produces a second accept.
- DONE:
  - Button ignored.
  - All outputs held until reset or restart.
  - current_player stays at its last value.
- Glitches:
  - A btn_s pulse shorter than DEBOUNCE_CYCLES produces no event, in either direction.
- Restart or reset mid-operation:
  - Discards partial counts, including a press currently being debounced.
  - After release of reset/restart, a button that is still held is not accepted until it has been seen low and stable first. The debounced level restarts at 0, so a held button does debounce again; this is intended and must be documented to users as "release before reset".
- Widths:
  - No arithmetic on counts beyond compares.
  - current_player increments without wrap, because the last player always goes to DONE.

Decomposition:
- battleship_cfg_pkg holds:
  - the state enum (WAIT_PRESS, WAIT_RELEASE, DONE)
  - function cnt_width(max) returning $clog2(max+1)
  - default constants MAX_SHIPS_DEF and MIN_SHIPS_DEF
- One sub-module, btn_debouncer:
  - contains the 2-flop synchroniser, debounce counter and debounced level
  - outputs single-cycle rise and fall pulses
  - parameter DEBOUNCE_CYCLES
  - reused later by the fire/shot button

Test Plan:
- Reset: after reset, all outputs are 0. Hold select_btn = 1 with value 3 across reset deassertion → nothing latched until the button is released and pressed again.
- Nominal, defaults: press value 3 → ship_count[2:0] = 3, count_valid = 01, current_player = 1, update at E+5. Release, then press value 2 → ship_count = {2,3}, count_valid = 11, select_done = 1.
- Range check: press value 0 → range_error high for 1 cycle, current_player = 0, count_valid = 00. Then press value 6 → same response. Then press value 5 → accepted.
- Bounce: btn pulses 3 cycles high/low repeatedly → no accept. A 10-cycle hold → exactly one accept, and no second accept while held for 200 cycles.
- SAME_COUNT = 1, NUM_PLAYERS = 3: press value 4 → all three slots = 4, count_valid = 111, select_done = 1 on the accept edge. Further presses change nothing.
- Restart: after player 0 latches 3, assert restart for 1 cycle while a press is mid-debounce → all outputs back to reset values, and the press is not accepted.
